// File: rtl/fwd_pkg.sv
// fwd_pkg: shared constants and helpers for the forwarding scoreboard
package fwd_pkg;
    localparam int SEL_REGFILE = 0;
    localparam int DEF_REG_AW = 5;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int sel_of_stage(input int k);
        return k + 1;
    endfunction
endpackage

// File: rtl/fwd_select.sv
// fwd_select: priority match of one source register against the bypass stages, youngest wins
module fwd_select
    import fwd_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int REG_AW = DEF_REG_AW,
    parameter int SEL_W = clog2(NUM_STAGES + 1)
) (
    input  logic [REG_AW-1:0]            rs,
    input  logic [NUM_STAGES*REG_AW-1:0] stage_rd,
    input  logic [NUM_STAGES-1:0]        stage_regwrite,
    output logic [SEL_W-1:0]             sel
);
    // scan oldest to youngest so the youngest live match overwrites
    always_comb begin
        sel = SEL_W'(SEL_REGFILE);
        for (int k = NUM_STAGES - 1; k >= 0; k--)
            if (stage_regwrite[k] && stage_rd[k*REG_AW +: REG_AW] != '0 &&
                stage_rd[k*REG_AW +: REG_AW] == rs)
                sel = SEL_W'(sel_of_stage(k));
    end
endmodule

// File: rtl/forwarding_scoreboard.sv
// forwarding_scoreboard: bypass select plus countdown scoreboard stall; FWD_PERF_CNT_EN adds perf counters
module forwarding_scoreboard
    import fwd_pkg::*;
#(
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_STAGES = 2,
    parameter int REG_AW = DEF_REG_AW,
    parameter int MAX_LAT = 7,
    localparam int SEL_W = clog2(NUM_STAGES + 1),
    localparam int LAT_W = clog2(MAX_LAT + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_RD_PORTS*REG_AW-1:0] rs,
    input  logic [NUM_RD_PORTS-1:0]        rs_used,
    input  logic [NUM_STAGES*REG_AW-1:0]   stage_rd,
    input  logic [NUM_STAGES-1:0]          stage_regwrite,
    input  logic                           issue_valid,
    input  logic [REG_AW-1:0]              issue_rd,
    input  logic                           issue_regwrite,
    input  logic [LAT_W-1:0]               issue_lat,
    input  logic                           flush,
`ifdef FWD_PERF_CNT_EN
    output logic [31:0]                    perf_stall_cnt,
    output logic [31:0]                    perf_fwd_cnt,
`endif
    output logic [NUM_RD_PORTS*SEL_W-1:0]  fwd_sel,
    output logic                           stall,
    output logic                           issue_fire
);
    localparam int NREG = 1 << REG_AW;

    logic [LAT_W-1:0] cnt [1:NREG-1];
    logic [LAT_W-1:0] cnt_next [1:NREG-1];
    logic [LAT_W-1:0] cnt_view [NREG];
    logic [LAT_W-1:0] lat_sat;
    logic hazard;
    logic wr;

    genvar g;
    for (g = 0; g < NUM_RD_PORTS; g++) begin : g_sel
        fwd_select #(.NUM_STAGES(NUM_STAGES), .REG_AW(REG_AW), .SEL_W(SEL_W)) u_sel (
            .rs(rs[g*REG_AW +: REG_AW]),
            .stage_rd(stage_rd),
            .stage_regwrite(stage_regwrite),
            .sel(fwd_sel[g*SEL_W +: SEL_W])
        );
    end

    // x0 has no counter; present it as a permanent zero for the lookup
    always_comb begin
        cnt_view[0] = '0;
        for (int r = 1; r < NREG; r++) cnt_view[r] = cnt[r];
    end

    // any used, nonzero source whose producer has not yet reached a bypass stage
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < NUM_RD_PORTS; i++)
            if (rs_used[i] && rs[i*REG_AW +: REG_AW] != '0 &&
                cnt_view[rs[i*REG_AW +: REG_AW]] != '0)
                hazard = 1'b1;
    end

    assign stall = issue_valid & ~flush & hazard;
    assign issue_fire = issue_valid & ~stall & ~flush;
    assign lat_sat = (int'(issue_lat) > MAX_LAT) ? LAT_W'(MAX_LAT) : issue_lat;
    assign wr = issue_fire & issue_regwrite & (issue_rd != '0) & (lat_sat != '0);

    // decrement every counter; a new producer only ever lengthens the wait (WAW safe)
    always_comb begin
        for (int r = 1; r < NREG; r++) begin
            cnt_next[r] = (cnt[r] != '0) ? cnt[r] - 1'b1 : '0;
            if (wr && issue_rd == REG_AW'(r) && lat_sat > cnt_next[r]) cnt_next[r] = lat_sat;
        end
    end

    // scoreboard register; reset abandons any countdown in progress
    always_ff @(posedge clk) begin
        for (int r = 1; r < NREG; r++) cnt[r] <= reset ? '0 : cnt_next[r];
    end

`ifdef FWD_PERF_CNT_EN
    logic fwd_any;

    // an issued instruction took at least one operand from a bypass stage
    always_comb begin
        fwd_any = 1'b0;
        for (int i = 0; i < NUM_RD_PORTS; i++)
            if (rs_used[i] && fwd_sel[i*SEL_W +: SEL_W] != SEL_W'(SEL_REGFILE)) fwd_any = 1'b1;
    end

    // free-running event counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_fwd_cnt <= '0;
        end else begin
            perf_stall_cnt <= perf_stall_cnt + 32'(stall);
            perf_fwd_cnt <= perf_fwd_cnt + 32'(issue_fire & fwd_any);
        end
    end
`endif
endmodule

// File: tb/tb_forwarding_scoreboard.sv
// tb_forwarding_scoreboard: directed vectors with a queued-expectation scoreboard
module tb_forwarding_scoreboard;
    logic clk = 1'b0;
    logic reset;
    logic [9:0] rs;
    logic [1:0] rs_used;
    logic [9:0] stage_rd;
    logic [1:0] stage_regwrite;
    logic issue_valid;
    logic [4:0] issue_rd;
    logic issue_regwrite;
    logic [2:0] issue_lat;
    logic flush;
    logic [3:0] fwd_sel;
    logic stall;
    logic issue_fire;
`ifdef FWD_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_fwd_cnt;
`endif

    typedef struct packed {
        logic [7:0] id;
        logic [1:0] s0;
        logic [1:0] s1;
        logic st;
        logic fi;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_fail = 0;

    forwarding_scoreboard dut (
        .clk(clk),
        .reset(reset),
        .rs(rs),
        .rs_used(rs_used),
        .stage_rd(stage_rd),
        .stage_regwrite(stage_regwrite),
        .issue_valid(issue_valid),
        .issue_rd(issue_rd),
        .issue_regwrite(issue_regwrite),
        .issue_lat(issue_lat),
        .flush(flush),
`ifdef FWD_PERF_CNT_EN
        .perf_stall_cnt(perf_stall_cnt),
        .perf_fwd_cnt(perf_fwd_cnt),
`endif
        .fwd_sel(fwd_sel),
        .stall(stall),
        .issue_fire(issue_fire)
    );

    always #5 clk = ~clk;

    task automatic check(input logic [7:0] id, input string what, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec%0d %s: got %0d expected %0d", id, what, act, exp);
        end
    endtask

    // monitor: outputs are sampled mid-cycle against the oldest queued expectation
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check(e.id, "fwd_sel0", 32'(fwd_sel[1:0]), 32'(e.s0));
            check(e.id, "fwd_sel1", 32'(fwd_sel[3:2]), 32'(e.s1));
            check(e.id, "stall", 32'(stall), 32'(e.st));
            check(e.id, "issue_fire", 32'(issue_fire), 32'(e.fi));
        end
    end

    task automatic vec(input logic chk, input logic [7:0] id, input logic [1:0] s0, input logic [1:0] s1,
                       input logic st, input logic fi);
        if (chk) q.push_back('{id, s0, s1, st, fi});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs = '0; rs_used = '0; stage_rd = '0; stage_regwrite = '0;
        issue_valid = 1'b0; issue_rd = '0; issue_regwrite = 1'b0; issue_lat = '0; flush = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [2:0] lat);
        idle();
        issue_valid = 1'b1; issue_rd = rd; issue_regwrite = 1'b1; issue_lat = lat;
    endtask

    task automatic reader(input logic [4:0] r);
        idle();
        issue_valid = 1'b1; rs[4:0] = r; rs_used = 2'b01;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        issue_valid = 1'b1;
        vec(1, 1, 0, 0, 0, 1);
        idle(); stage_rd = {5'd5, 5'd5}; stage_regwrite = 2'b11; rs = {5'd0, 5'd5};
        vec(1, 2, 1, 0, 0, 0);
        stage_regwrite = 2'b10;
        vec(1, 3, 2, 0, 0, 0);
        idle(); stage_rd = {5'd5, 5'd0}; stage_regwrite = 2'b11; rs = {5'd0, 5'd5};
        rs_used = 2'b11; issue_valid = 1'b1;
        vec(1, 4, 2, 0, 0, 1);
        issue(7, 2);
        vec(1, 5, 0, 0, 0, 1);
        reader(7);
        vec(1, 6, 0, 0, 1, 0);
        vec(1, 7, 0, 0, 1, 0);
        stage_rd = {5'd0, 5'd7}; stage_regwrite = 2'b01;
        vec(1, 8, 1, 0, 0, 1);
        issue(9, 5);
        vec(1, 9, 0, 0, 0, 1);
        issue(9, 1);
        vec(1, 10, 0, 0, 0, 1);
        reader(9);
        vec(1, 11, 0, 0, 1, 0);
        vec(1, 12, 0, 0, 1, 0);
        vec(1, 13, 0, 0, 1, 0);
        vec(1, 14, 0, 0, 1, 0);
        vec(1, 15, 0, 0, 0, 1);
        issue(3, 3);
        vec(1, 16, 0, 0, 0, 1);
        reader(3); flush = 1'b1;
        vec(1, 17, 0, 0, 0, 0);
        flush = 1'b0;
        vec(1, 18, 0, 0, 1, 0);
        vec(1, 19, 0, 0, 1, 0);
        vec(1, 20, 0, 0, 0, 1);
        issue(4, 6);
        vec(1, 21, 0, 0, 0, 1);
        reader(4);
        vec(1, 22, 0, 0, 1, 0);
        reset = 1'b1;
        vec(0, 23, 0, 0, 0, 0);
        reset = 1'b0;
`ifdef FWD_PERF_CNT_EN
        check(24, "perf_stall_cnt", perf_stall_cnt, 0);
        check(24, "perf_fwd_cnt", perf_fwd_cnt, 0);
`endif
        vec(1, 24, 0, 0, 0, 1);
        idle();
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end
endmodule
